// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO family.
// Width/depth defaults and the pointer-width rule are reused by future variants.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 8;
  localparam int DEFAULT_ADDRESS_WIDTH = 4;

  // One extra pointer bit separates the full and empty cases when the low bits match.
  function automatic int ptr_width(input int address_width);
    return address_width + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port and one registered read port.
// There is no reset, so the array maps onto block RAM.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_en,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  // The read register holds its value between reads.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_reg <= mem_reg[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO control: pointers, occupancy, status flags and sticky errors.
// Storage lives in fifo_ram; data_out is masked to zero until the first pop after reset.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH   = DEFAULT_ADDRESS_WIDTH,
  parameter int ALMOST_FULL_TH  = (1 << ADDRESS_WIDTH) - 2,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic                     err_clr,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     rd_valid,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [ADDRESS_WIDTH:0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam int PW    = ptr_width(ADDRESS_WIDTH);
  localparam logic [PW-1:0] AF_TH = PW'(ALMOST_FULL_TH);
  localparam logic [PW-1:0] AE_TH = PW'(ALMOST_EMPTY_TH);

  generate
    if (ADDRESS_WIDTH < 1) begin : g_bad_aw
      $error("sync_fifo: ADDRESS_WIDTH must be at least 1");
    end
    if (!((ALMOST_EMPTY_TH < ALMOST_FULL_TH) && (ALMOST_FULL_TH <= DEPTH))) begin : g_bad_th
      $error("sync_fifo: thresholds must satisfy ALMOST_EMPTY_TH < ALMOST_FULL_TH <= DEPTH");
    end
  endgenerate

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] count_reg;
  logic          overflow_reg, overflow_next;
  logic          underflow_reg, underflow_next;
  logic          rd_valid_reg;
  logic          dout_loaded_reg;
  logic          full_flag, empty_flag;
  logic          push_ok, pop_ok;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Flags come only from registered pointers, never from wr_en/rd_en.
  assign empty_flag = (wr_ptr_reg == rd_ptr_reg);
  assign full_flag  = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                      (wr_ptr_reg[PW-2:0] == rd_ptr_reg[PW-2:0]);

  assign push_ok = wr_en && !full_flag;
  assign pop_ok  = rd_en && !empty_flag;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    overflow_next  = overflow_reg && !err_clr;
    underflow_next = underflow_reg && !err_clr;
    if (push_ok) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    // A fresh error outranks a clear in the same cycle.
    if (wr_en && full_flag) begin
      overflow_next = 1'b1;
    end
    if (rd_en && empty_flag) begin
      underflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      overflow_reg    <= 1'b0;
      underflow_reg   <= 1'b0;
      rd_valid_reg    <= 1'b0;
      dout_loaded_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= wr_ptr_next - rd_ptr_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
      rd_valid_reg  <= pop_ok;
      if (pop_ok) begin
        dout_loaded_reg <= 1'b1;
      end
    end
  end

  fifo_ram #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr_reg[PW-2:0]),
    .wr_data (data_in),
    .rd_en   (pop_ok),
    .rd_addr (rd_ptr_reg[PW-2:0]),
    .rd_data (ram_rdata)
  );

  // The RAM read register has no reset, so hide its stale value until a pop reloads it.
  assign data_out     = dout_loaded_reg ? ram_rdata : '0;
  assign rd_valid     = rd_valid_reg;
  assign fifo_full    = full_flag;
  assign fifo_empty   = empty_flag;
  assign almost_full  = (count_reg >= AF_TH);
  assign almost_empty = (count_reg <= AE_TH);
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed steps plus a random phase,
// checked against a queue-based reference model.
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF_TH = 14;
  localparam int AE_TH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] data_in;
  logic          wr_en, rd_en, err_clr;
  logic [DW-1:0] data_out;
  logic          rd_valid, fifo_full, fifo_empty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  int total = 0;
  int bad   = 0;

  logic [7:0] q[$];
  logic [7:0] m_dout;
  bit         m_valid, m_ovf, m_udf;

  sync_fifo dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .err_clr      (err_clr),
    .data_out     (data_out),
    .rd_valid     (rd_valid),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string ctx);
    int n;
    n = q.size();
    check({ctx, ":count"},        32'(count),        32'(n));
    check({ctx, ":fifo_full"},    32'(fifo_full),    32'(n == DEPTH));
    check({ctx, ":fifo_empty"},   32'(fifo_empty),   32'(n == 0));
    check({ctx, ":almost_full"},  32'(almost_full),  32'(n >= AF_TH));
    check({ctx, ":almost_empty"}, 32'(almost_empty), 32'(n <= AE_TH));
    check({ctx, ":rd_valid"},     32'(rd_valid),     32'(m_valid));
    check({ctx, ":data_out"},     32'(data_out),     32'(m_dout));
    check({ctx, ":overflow"},     32'(overflow),     32'(m_ovf));
    check({ctx, ":underflow"},    32'(underflow),    32'(m_udf));
  endtask

  task automatic model_reset();
    q.delete();
    m_dout  = 8'h00;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  // One clock of stimulus, entered and left just after a falling edge.
  task automatic step(input string ctx, input bit w, input bit r, input bit clr,
                      input logic [7:0] d);
    bit full_now, empty_now;
    wr_en   = w;
    rd_en   = r;
    err_clr = clr;
    data_in = d;
    full_now  = (q.size() == DEPTH);
    empty_now = (q.size() == 0);
    @(posedge clk);
    m_valid = r && !empty_now;
    if (m_valid) m_dout = q.pop_front();
    if (w && !full_now) q.push_back(d);
    m_ovf = (m_ovf && !clr) || (w && full_now);
    m_udf = (m_udf && !clr) || (r && empty_now);
    #1 check_all(ctx);
    @(negedge clk);
  endtask

  task automatic async_reset(input string ctx);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all(ctx);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    data_in = '0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    model_reset();
    #1 check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill 0x01..0x10, then one push too many.
    for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, 1'b0, 1'b0, 8'(i));
    step("push_when_full", 1'b1, 1'b0, 1'b0, 8'h11);

    // Clear without a new error, then clear colliding with a rejected push.
    step("clr_only", 1'b0, 1'b0, 1'b1, 8'h00);
    step("ovf_again", 1'b1, 1'b0, 1'b0, 8'h22);
    step("clr_vs_ovf", 1'b1, 1'b0, 1'b1, 8'h23);
    step("clr_after", 1'b0, 1'b0, 1'b1, 8'h00);

    // Drain in order, then one extra pop.
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 1'b1, 1'b0, 8'h00);
    step("hold_idle", 1'b0, 1'b0, 1'b0, 8'h00);
    step("pop_when_empty", 1'b0, 1'b1, 1'b0, 8'h00);

    // Empty with both requests: push accepted, pop rejected.
    step("empty_both", 1'b1, 1'b1, 1'b0, 8'h5A);
    step("clr_udf", 1'b0, 1'b0, 1'b1, 8'h00);

    // Refill to full and then push+pop together.
    for (int i = 0; i < DEPTH - 1; i++) step("refill", 1'b1, 1'b0, 1'b0, 8'($urandom));
    step("full_both", 1'b1, 1'b1, 1'b0, 8'hEE);
    step("clr_ovf", 1'b0, 1'b0, 1'b1, 8'h00);

    // Steady state at count=5 long enough for the pointers to wrap.
    async_reset("reset_before_steady");
    for (int i = 0; i < 5; i++) step("prefill5", 1'b1, 1'b0, 1'b0, 8'($urandom));
    for (int i = 0; i < 40; i++) step("steady", 1'b1, 1'b1, 1'b0, 8'($urandom));

    // Asynchronous reset mid-fill at count=7; stored entries are discarded.
    async_reset("reset_before_fill7");
    for (int i = 0; i < 7; i++) step("fill7", 1'b1, 1'b0, 1'b0, 8'(8'h30 + i));
    async_reset("reset_mid_fill");
    step("post_reset_push", 1'b1, 1'b0, 1'b0, 8'hAA);
    step("post_reset_pop", 1'b0, 1'b1, 1'b0, 8'h00);
    step("post_reset_idle", 1'b0, 1'b0, 1'b0, 8'h00);

    // Random traffic, write-biased first then read-biased to sweep all levels.
    for (int i = 0; i < 400; i++) begin
      bit w, r, c;
      if (i < 200) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      c = ($urandom_range(0, 7) == 0);
      step("random", w, r, c, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
- REQ-001 Parameter DATA_WIDTH, default 8: data bits per entry.
- REQ-002 Parameter ADDRESS_WIDTH, default 4: address bits; DEPTH SHALL equal 2**ADDRESS_WIDTH.
- REQ-003 Parameter ALMOST_FULL_TH, default DEPTH-2: almost_full asserts when count >= this value.
- REQ-004 Parameter ALMOST_EMPTY_TH, default 2: almost_empty asserts when count <= this value.
- REQ-005 clk, input, 1: single clock; all state updates on rising edge.
- REQ-006 rst_n, input, 1: reset, asynchronous, active-low.
- REQ-007 data_in, input, DATA_WIDTH: write data.
- REQ-008 wr_en, input, 1: push request.
- REQ-009 rd_en, input, 1: pop request.
- REQ-010 data_out, output, DATA_WIDTH: registered read data.
- REQ-011 rd_valid, output, 1: one-cycle pulse, data_out holds popped word.
- REQ-012 fifo_full, fifo_empty, almost_full, almost_empty, output, 1 each: status flags.
- REQ-013 count, output, ADDRESS_WIDTH+1: current occupancy, 0..DEPTH.
- REQ-014 overflow, underflow, output, 1 each: sticky error flags.
- REQ-015 err_clr, input, 1: clears overflow and underflow.

Function
- REQ-016 Push SHALL be accepted when wr_en=1 and fifo_full=0 (flag value at start of cycle); data_in written to mem[wr_ptr], wr_ptr increments.
- REQ-017 Pop SHALL be accepted when rd_en=1 and fifo_empty=0; data_out loads mem[rd_ptr] at that edge, rd_ptr increments, rd_valid=1 the following cycle only.
- REQ-018 Read latency SHALL be one clock from accepted rd_en to valid data_out; data_out SHALL hold its last value when no pop is accepted.
- REQ-019 Pointers SHALL be ADDRESS_WIDTH+1 bits, wrap modulo 2*DEPTH; low bits address memory.
- REQ-020 fifo_empty SHALL be 1 when pointers are equal; fifo_full SHALL be 1 when MSBs differ and low bits are equal.
- REQ-021 count SHALL be wr_ptr - rd_ptr (ADDRESS_WIDTH+1 bit modular subtract), registered; flags derived from registered state, no combinational path from wr_en/rd_en.
- REQ-022 Simultaneous accepted push and pop SHALL leave count unchanged; both pointers advance.
- REQ-023 When full, wr_en=1 and rd_en=1: pop accepted, push rejected, overflow set.
- REQ-024 When empty, wr_en=1 and rd_en=1: push accepted, pop rejected, underflow set, rd_valid stays 0.
- REQ-025 Rejected push SHALL set overflow; rejected pop SHALL set underflow; memory and pointers unchanged.
- REQ-026 err_clr SHALL clear sticky flags next edge; a new error in the same cycle as err_clr SHALL win (flag set).
- REQ-027 Write to a location and pop of the same location in one cycle cannot occur (empty gating); no read-during-write bypass required.

Reset
- REQ-028 rst_n=0 SHALL immediately clear wr_ptr, rd_ptr, count, data_out, rd_valid, overflow, underflow; fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0.
- REQ-029 Memory contents SHALL NOT be reset.
- REQ-030 Reset asserted mid-operation SHALL discard all stored entries; first pop after release returns first post-reset push.

Structure
- REQ-031 A shared package fifo_pkg SHALL hold default width/depth constants and the ptr-width derivation function, reused by future FIFO variants.
- REQ-032 Storage SHALL be a sub-module fifo_ram (write port + registered read port, no reset), instantiated once; control logic in sync_fifo.
- REQ-033 Parameter checks: ALMOST_EMPTY_TH < ALMOST_FULL_TH <= DEPTH, elaboration error otherwise.

Verification
- REQ-034 Reset, push 0x01..0x10 (DEPTH=16) -> fifo_full=1, count=16, almost_full from count 14; 17th push sets overflow.
- REQ-035 Pop 16 after fill -> data_out 0x01..0x10 in order, each one cycle after rd_en, rd_valid pulses 16 times; fifo_empty=1; extra pop sets underflow.
- REQ-036 Steady simultaneous push/pop at count=5 for 40 cycles -> count stays 5, pointers wrap past 32, data order preserved.
- REQ-037 Full + wr_en + rd_en -> count 15, overflow=1, popped word correct; empty + both -> count 1, underflow=1, rd_valid=0.
- REQ-038 rst_n low mid-fill (count=7) asynchronously between edges -> outputs cleared immediately; after release push 0xAA, pop -> data_out=0xAA.
- REQ-039 err_clr with overflow set and no new error -> overflow=0 next cycle; err_clr coincident with rejected push -> overflow stays 1.
